regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the ID-stage register file.
- Provides NUM_RD registered read ports and one write port.
- Write-to-read bypass; ZERO/ONE constant pseudo-registers; well-defined handling of out-of-range selectors.
- Per-register pending-write scoreboard that flags read-after-write hazards to the pipeline control, so decode can stall instead of reading stale data.

Parameters:
- DATA_W, 16, register/data width in bits
- ADDR_W, 4, selector width
- NUM_REGS, 8, physical registers R0..R(NUM_REGS-1), selector codes 0..NUM_REGS-1; must be ≤ 2^ADDR_W-2
- NUM_RD, 2, number of read ports
- ZERO_CODE, 14, selector code that reads constant 0
- ONE_CODE, 15, selector code that reads constant 1

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_sel  in  NUM_RD*ADDR_W  read selectors; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_hold  in  1  pipeline stall: all rd_data hold their value
- rd_data  out  NUM_RD*DATA_W  registered read data; port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  combinational hazard flag per read port
- wr_en  in  1  writeback strobe
- wr_sel  in  ADDR_W  writeback register
- wr_data  in  DATA_W  writeback data
- rsv_en  in  1  decode issued an instruction that will write rsv_sel
- rsv_sel  in  ADDR_W  register being reserved
- pending  out  NUM_REGS  scoreboard bits, bit i = Ri awaiting writeback
- any_pending  out  1  OR of pending

Behaviour:
- Reset (async, immediate):
  - all registers, rd_data and pending are cleared to 0.
  - rd_busy and any_pending therefore read 0.
- Write:
  - On a rising edge with wr_en=1 and wr_sel < NUM_REGS, R[wr_sel] <= wr_data.
  - Writes to ZERO_CODE, ONE_CODE or any unmapped code are dropped.
- Read:
  - 1-cycle latency. On each rising edge with rd_hold=0, port k loads:
    - ZERO_CODE → 0
    - ONE_CODE → 1, zero-extended
    - code < NUM_REGS → R[code]
    - any other code → 0
  - rd_hold=1 keeps every rd_data unchanged; register writes and scoreboard updates still occur.
- Bypass:
  - If wr_en=1 and wr_sel equals a port's selector (a mapped register) on the same edge, that port loads wr_data, not the old register value.
  - All ports selecting the same register get identical data.
- Scoreboard, per register i, on each rising edge:
  - rsv_en=1 and rsv_sel=i → pending[i] <= 1.
  - Otherwise, wr_en=1 and wr_sel=i → pending[i] <= 0.
  - Simultaneous reserve and writeback of the same register: reserve wins and the bit stays 1, because the new writer is younger.
  - Reserve or writeback of an unmapped code has no effect.
  - Writeback of a register that is not pending still writes data; pending stays 0.
- rd_busy[k] is combinational: 1 when rd_sel_k < NUM_REGS, pending[rd_sel_k]=1, and NOT (wr_en=1 and wr_sel=rd_sel_k).
  - An in-flight writeback in the same cycle resolves the hazard via bypass.
  - Constant and unmapped selectors are never busy.
- any_pending = |pending, combinational from the state.
- No internal FSM beyond the per-register scoreboard bits. Integration rule: decode must drive rsv_en=0 while any rd_busy is 1.

Test Plan:
- Reset, then write R1=0x1234 and R2=0xBEEF. Set rd_sel0=1, rd_sel1=2 → one cycle later rd_data0=0x1234, rd_data1=0xBEEF, rd_busy=0.
- rd_sel0=ZERO_CODE(14), rd_sel1=ONE_CODE(15); write 0xFFFF to code 14 and to code 9 → reads stay 0x0000 and 0x0001; R0..R7 unchanged.
- Same-edge wr_en=1, wr_sel=3, wr_data=0xA5A5 with rd_sel0=rd_sel1=3 → both rd_data = 0xA5A5 after the edge.
- rsv_en with rsv_sel=2 → pending=0x04, any_pending=1. With rd_sel0=2: rd_busy0=1 with no write in flight, and rd_busy0=0 in the writeback cycle. After the writeback edge, pending=0x00.
- Same edge: rsv_en rsv_sel=5 and wr_en wr_sel=5 while pending[5]=1 → pending[5] stays 1. rd_hold=1 for 3 cycles while R1 changes → rd_data frozen, then updates on release.
- Assert rst mid-operation with pending=0xFF and nonzero rd_data, no clock edge → pending, rd_data and registers are 0 immediately. After deassert, reading R1 returns 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with NUM_RD registered read ports, one write port, write-to-read bypass,
// ZERO/ONE constant selectors and a per-register pending-write scoreboard for RAW hazards.
module regfile_scoreboard #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int NUM_REGS  = 8,
  parameter int NUM_RD    = 2,
  parameter int ZERO_CODE = 14,
  parameter int ONE_CODE  = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_sel,
  input  logic                       rd_hold,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_sel,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_sel,
  output logic [NUM_REGS-1:0]        pending,
  output logic                       any_pending
);

  localparam logic [ADDR_W-1:0] ONE_SEL = ADDR_W'(ONE_CODE);

  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [DATA_W-1:0]        regs_d [NUM_REGS];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_REGS-1:0]      pending_q, pending_d;

  logic [ADDR_W-1:0]        port_sel [NUM_RD];
  logic [DATA_W-1:0]        port_val [NUM_RD];
  logic                     port_byp [NUM_RD];

  // A reservation from a younger instruction beats a same-cycle writeback of an older one.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && (wr_sel == ADDR_W'(i))) begin
        regs_d[i] = wr_data;
      end
      pending_d[i] = (rsv_en && (rsv_sel == ADDR_W'(i)))
                   | (pending_q[i] & ~(wr_en && (wr_sel == ADDR_W'(i))));
    end
  end

  // ZERO_CODE and unmapped codes fall through to the all-zero default value.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy   = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      port_sel[k] = rd_sel[k*ADDR_W +: ADDR_W];
      port_byp[k] = wr_en && (wr_sel == port_sel[k]);
      port_val[k] = '0;
      for (int j = 0; j < NUM_REGS; j++) begin
        if (port_sel[k] == ADDR_W'(j)) begin
          port_val[k] = port_byp[k] ? wr_data : regs_q[j];
          rd_busy[k]  = pending_q[j] & ~port_byp[k];
        end
      end
      if (port_sel[k] == ONE_SEL) begin
        port_val[k] = DATA_W'(1);
      end
      if (!rd_hold) begin
        rd_data_d[k*DATA_W +: DATA_W] = port_val[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      rd_data_q <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      rd_data_q <= rd_data_d;
      pending_q <= pending_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign pending     = pending_q;
  assign any_pending = |pending_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized checks of regfile_scoreboard against a behavioural model
// of the register array, read ports and scoreboard.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rd_sel;
  logic        rd_hold;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [15:0] wr_data;
  logic        rsv_en;
  logic [3:0]  rsv_sel;
  logic [7:0]  pending;
  logic        any_pending;

  int checks = 0;
  int errors = 0;

  logic [15:0] mRegs [8];
  logic [7:0]  mPend;
  logic [15:0] mRd [2];

  regfile_scoreboard #(
    .DATA_W(16), .ADDR_W(4), .NUM_REGS(8), .NUM_RD(2), .ZERO_CODE(14), .ONE_CODE(15)
  ) dut (
    .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_hold(rd_hold), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .pending(pending), .any_pending(any_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Value a port should capture on the coming edge, given the current inputs.
  function automatic logic [15:0] modelRead(input logic [3:0] sel);
    if (sel == 4'd14) return 16'h0000;
    if (sel == 4'd15) return 16'h0001;
    if (sel < 4'd8) return (wr_en && wr_sel == sel) ? wr_data : mRegs[sel[2:0]];
    return 16'h0000;
  endfunction

  function automatic logic modelBusy(input logic [3:0] sel);
    if (sel >= 4'd8) return 1'b0;
    return mPend[sel[2:0]] && !(wr_en && wr_sel == sel);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mRegs[i] = 16'h0000;
    mPend  = 8'h00;
    mRd[0] = 16'h0000;
    mRd[1] = 16'h0000;
  endtask

  task automatic modelEdge();
    logic [15:0] r0, r1;
    r0 = modelRead(rd_sel[3:0]);
    r1 = modelRead(rd_sel[7:4]);
    if (!rd_hold) begin
      mRd[0] = r0;
      mRd[1] = r1;
    end
    if (wr_en && wr_sel < 4'd8) begin
      mRegs[wr_sel[2:0]] = wr_data;
      mPend[wr_sel[2:0]] = 1'b0;
    end
    if (rsv_en && rsv_sel < 4'd8) mPend[rsv_sel[2:0]] = 1'b1;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".rd0"}, 32'(rd_data[15:0]), 32'(mRd[0]));
    checkValue({tag, ".rd1"}, 32'(rd_data[31:16]), 32'(mRd[1]));
    checkValue({tag, ".pending"}, 32'(pending), 32'(mPend));
    checkValue({tag, ".any_pending"}, 32'(any_pending), 32'(mPend != 8'h00));
  endtask

  task automatic applyStimulus(input logic [3:0] sel0, input logic [3:0] sel1, input logic hold,
                               input logic wen, input logic [3:0] wsel, input logic [15:0] wdata,
                               input logic ren, input logic [3:0] rsel);
    rd_sel  = {sel1, sel0};
    rd_hold = hold;
    wr_en   = wen;
    wr_sel  = wsel;
    wr_data = wdata;
    rsv_en  = ren;
    rsv_sel = rsel;
  endtask

  task automatic cycle(input string tag);
    #1;
    checkValue({tag, ".busy0"}, 32'(rd_busy[0]), 32'(modelBusy(rd_sel[3:0])));
    checkValue({tag, ".busy1"}, 32'(rd_busy[1]), 32'(modelBusy(rd_sel[7:4])));
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [3:0] s0, s1, ws, rs;
    logic       ren;

    rst = 1'b1;
    applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    checkValue("reset.busy", 32'(rd_busy), 32'h0);
    rst = 1'b0;

    // Basic write then read back
    applyStimulus(4'd0, 4'd0, 1'b0, 1'b1, 4'd1, 16'h1234, 1'b0, 4'd0);
    cycle("wrR1");
    applyStimulus(4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 16'hBEEF, 1'b0, 4'd0);
    cycle("wrR2");
    applyStimulus(4'd1, 4'd2, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    cycle("rdR1R2");
    checkValue("rdR1R2.const0", 32'(rd_data[15:0]), 32'h1234);
    checkValue("rdR1R2.const1", 32'(rd_data[31:16]), 32'hBEEF);

    // Constant selectors and dropped writes
    applyStimulus(4'd14, 4'd15, 1'b0, 1'b1, 4'd14, 16'hFFFF, 1'b0, 4'd0);
    cycle("wrZero");
    applyStimulus(4'd14, 4'd15, 1'b0, 1'b1, 4'd9, 16'hFFFF, 1'b0, 4'd0);
    cycle("wrUnmapped");
    checkValue("const.zero", 32'(rd_data[15:0]), 32'h0000);
    checkValue("const.one", 32'(rd_data[31:16]), 32'h0001);
    for (int j = 0; j < 4; j++) begin
      applyStimulus(4'(2*j), 4'(2*j+1), 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
      cycle("rdAll");
    end

    // Bypass to both ports
    applyStimulus(4'd3, 4'd3, 1'b0, 1'b1, 4'd3, 16'hA5A5, 1'b0, 4'd0);
    cycle("bypass");
    checkValue("bypass.const0", 32'(rd_data[15:0]), 32'hA5A5);
    checkValue("bypass.const1", 32'(rd_data[31:16]), 32'hA5A5);

    // Reserve, hazard, writeback
    applyStimulus(4'd14, 4'd15, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd2);
    cycle("rsv2");
    checkValue("rsv2.const_pending", 32'(pending), 32'h04);
    checkValue("rsv2.const_any", 32'(any_pending), 32'h1);
    applyStimulus(4'd2, 4'd15, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    #1;
    checkValue("hazard.const_busy0", 32'(rd_busy[0]), 32'h1);
    cycle("hazard");
    applyStimulus(4'd2, 4'd15, 1'b0, 1'b1, 4'd2, 16'h5A5A, 1'b0, 4'd0);
    #1;
    checkValue("wb2.const_busy0", 32'(rd_busy[0]), 32'h0);
    cycle("wb2");
    checkValue("wb2.const_pending", 32'(pending), 32'h00);
    checkValue("wb2.const_rd0", 32'(rd_data[15:0]), 32'h5A5A);

    // Reserve beats simultaneous writeback
    applyStimulus(4'd14, 4'd15, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5);
    cycle("rsv5");
    applyStimulus(4'd14, 4'd15, 1'b0, 1'b1, 4'd5, 16'h7777, 1'b1, 4'd5);
    cycle("rsvWb5");
    checkValue("rsvWb5.const_pending", 32'(pending), 32'h20);
    applyStimulus(4'd14, 4'd15, 1'b0, 1'b1, 4'd5, 16'h7778, 1'b0, 4'd0);
    cycle("wb5");

    // Hold freezes read data while R1 keeps changing
    applyStimulus(4'd1, 4'd2, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    cycle("preHold");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'd1, 4'd2, 1'b1, 1'b1, 4'd1, 16'(16'h0100 + i), 1'b0, 4'd0);
      cycle("hold");
      checkValue("hold.const_rd0", 32'(rd_data[15:0]), 32'h1234);
    end
    applyStimulus(4'd1, 4'd2, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    cycle("release");
    checkValue("release.const_rd0", 32'(rd_data[15:0]), 32'h0102);

    // Randomized traffic; reservations are suppressed while a port is busy
    repeat (400) begin
      s0  = 4'($urandom_range(0, 15));
      s1  = 4'($urandom_range(0, 15));
      ws  = 4'($urandom_range(0, 15));
      rs  = 4'($urandom_range(0, 15));
      ren = ($urandom_range(0, 2) == 0);
      applyStimulus(s0, s1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                    ws, 16'($urandom), 1'b0, rs);
      if (!(modelBusy(s0) || modelBusy(s1))) rsv_en = ren;
      cycle("random");
    end

    // Fill the scoreboard, then reset asynchronously between edges
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'd14, 4'd15, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'(i));
      cycle("fill");
    end
    checkValue("fill.const_pending", 32'(pending), 32'hFF);
    applyStimulus(4'd14, 4'd15, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("asyncRst");
    checkValue("asyncRst.const_rd", rd_data, 32'h0);
    checkValue("asyncRst.const_pending", 32'(pending), 32'h0);
    #1;
    rst = 1'b0;
    applyStimulus(4'd1, 4'd3, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    cycle("postRst");
    checkValue("postRst.const_rd0", 32'(rd_data[15:0]), 32'h0);
    checkValue("postRst.const_rd1", 32'(rd_data[31:16]), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
